// File: rtl/board_status_display.sv
// board_status_display: latches NoC data onto hex digits, drives a status digit and debounces the board keys.
module board_status_display #(
  parameter int DATA_WIDTH     = 32,
  parameter int N_DIGITS       = 5,
  parameter int HEARTBEAT_MSB  = 25,
  parameter int N_BUTTONS      = 2,
  parameter int DEBOUNCE_COUNT = 1250000,
  parameter int STALE_COUNT    = 50000000
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic [N_BUTTONS-1:0]    KeysRaw,
  output logic [N_BUTTONS-1:0]    Buttons,
  output logic [N_BUTTONS-1:0]    ButtonPress,
  input  logic [DATA_WIDTH-1:0]   DataIn,
  input  logic                    DataValid,
  input  logic                    Lockup,
  input  logic                    LzBlank,
  output logic [7*N_DIGITS-1:0]   Hex,
  output logic [6:0]              HexStatus,
  output logic                    Stale
);
  localparam int ND = DATA_WIDTH / 4;
  localparam int NV = ND < N_DIGITS ? ND : N_DIGITS;
  localparam int DW = DEBOUNCE_COUNT > 1 ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam int SW = $clog2(STALE_COUNT + 1);
  localparam logic [6:0] SEG_L = 7'b1000111, SEG_E = 7'b0000110, SEG_O = 7'b0100011, SEG_OFF = 7'b1111111;

  logic [DATA_WIDTH-1:0]          data_q, data_d;
  logic [SW-1:0]                  stale_cnt_q, stale_cnt_d;
  logic                           stale_q, stale_d;
  logic [7*N_DIGITS-1:0]          hex_q, hex_d;
  logic [6:0]                     status_q, status_d;
  logic [HEARTBEAT_MSB:0]         hb_cnt_q;
  logic                           hb_q;
  logic [N_BUTTONS-1:0]           sync1_q, sync2_q, btn_q, btn_d, press_q, press_d;
  logic [N_BUTTONS-1:0][DW-1:0]   db_cnt_q, db_cnt_d;
  logic                           lead;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'b1000000;
      4'h1: font = 7'b1111001;
      4'h2: font = 7'b0100100;
      4'h3: font = 7'b0110000;
      4'h4: font = 7'b0011001;
      4'h5: font = 7'b0010010;
      4'h6: font = 7'b0000010;
      4'h7: font = 7'b1111000;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0010000;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b0000011;
      4'hC: font = 7'b1000110;
      4'hD: font = 7'b0100001;
      4'hE: font = 7'b0000110;
      4'hF: font = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    data_d      = DataValid ? DataIn : data_q;
    stale_cnt_d = DataValid ? '0 : (stale_cnt_q == SW'(STALE_COUNT) ? stale_cnt_q : stale_cnt_q + 1'b1);
    stale_d     = DataValid ? 1'b0 : (stale_q | (stale_cnt_d == SW'(STALE_COUNT)));
    status_d    = Lockup ? SEG_L : stale_q ? SEG_E : hb_q ? SEG_O : SEG_OFF;
    hex_d       = '1;
    lead        = 1'b1;
    // Walk from the most significant displayed nibble so lead tracks "all zero so far".
    for (int i = NV - 1; i >= 0; i--) begin
      lead = lead & (data_q[4*i +: 4] == 4'h0);
      hex_d[7*i +: 7] = (LzBlank && lead && i > 0) ? SEG_OFF : font(data_q[4*i +: 4]);
    end
    btn_d    = btn_q;
    db_cnt_d = '0;
    for (int k = 0; k < N_BUTTONS; k++) begin
      if (sync2_q[k] != btn_q[k]) begin
        if (db_cnt_q[k] == DW'(DEBOUNCE_COUNT - 1)) btn_d[k] = sync2_q[k];
        else db_cnt_d[k] = db_cnt_q[k] + 1'b1;
      end
    end
    press_d = btn_d & ~btn_q;
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      data_q      <= '0;
      stale_cnt_q <= '0;
      stale_q     <= 1'b1;
      hex_q       <= '1;
      status_q    <= SEG_OFF;
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      btn_q       <= '0;
      press_q     <= '0;
      db_cnt_q    <= '0;
    end else begin
      data_q      <= data_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
      hex_q       <= hex_d;
      status_q    <= status_d;
      hb_cnt_q    <= hb_cnt_q + 1'b1;
      hb_q        <= hb_cnt_q[HEARTBEAT_MSB] & hb_cnt_q[HEARTBEAT_MSB-2];
      sync1_q     <= ~KeysRaw;
      sync2_q     <= sync1_q;
      btn_q       <= btn_d;
      press_q     <= press_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  assign Hex         = hex_q;
  assign HexStatus   = status_q;
  assign Stale       = stale_q;
  assign Buttons     = btn_q;
  assign ButtonPress = press_q;
endmodule
